ef_bus_arbiter: RTL and testbench



---
 rtl/ef_bus_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_ef_bus_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ef_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ef_bus_arbiter
//   Round-robin arbiter and access sequencer for the shared Flash/Ethernet
//   tri-state bus. Two requesters contend for the bus: m0 is the CFI flash
//   port and m1 is the LAN91C111 port. The winner gets one
//   SETUP/STROBE/HOLD/TURN access, with wait states set per target.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   m0_req/we/adr/wdat         flash request (level, held until m0_ack)
//   m0_rdat, m0_ack            flash read data, one-cycle completion pulse
//   m1_req/we/adr/wdat/be_n    ethernet request, active-low byte enables
//   m1_rdat, m1_ack            ethernet read data, one-cycle completion pulse
//   ef_a, ef_d_o, ef_d_oe      shared address, data out, data output enable
//   ef_d_i                     shared data in
//   flash_ce_n/oe_n/we_n       flash strobes
//   enet_rd_n/wr_n, enet_be_n  ethernet strobes and byte enables
//
// Every output is a register. Each output takes the value it must have in
// the state being entered, so outputs change on the same edge as the state.
// ---------------------------------------------------------------------------
module ef_bus_arbiter #(
    parameter int FL_SETUP  = 1,
    parameter int FL_STROBE = 6,
    parameter int FL_HOLD   = 1,
    parameter int EN_SETUP  = 1,
    parameter int EN_STROBE = 3,
    parameter int EN_HOLD   = 1,
    parameter int CNT_W     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [22:0] m0_adr,
    input  logic [31:0] m0_wdat,
    output logic [31:0] m0_rdat,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [22:0] m1_adr,
    input  logic [31:0] m1_wdat,
    input  logic [3:0]  m1_be_n,
    output logic [31:0] m1_rdat,
    output logic        m1_ack,
    output logic [22:0] ef_a,
    output logic [31:0] ef_d_o,
    output logic        ef_d_oe,
    input  logic [31:0] ef_d_i,
    output logic        flash_ce_n,
    output logic        flash_oe_n,
    output logic        flash_we_n,
    output logic        enet_rd_n,
    output logic        enet_wr_n,
    output logic [3:0]  enet_be_n
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_t;

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] FL_SETUP_C  = CNT_W'(FL_SETUP - 1);
    localparam logic [CNT_W-1:0] FL_STROBE_C = CNT_W'(FL_STROBE - 1);
    localparam logic [CNT_W-1:0] FL_HOLD_C   = CNT_W'(FL_HOLD - 1);
    localparam logic [CNT_W-1:0] EN_SETUP_C  = CNT_W'(EN_SETUP - 1);
    localparam logic [CNT_W-1:0] EN_STROBE_C = CNT_W'(EN_STROBE - 1);
    localparam logic [CNT_W-1:0] EN_HOLD_C   = CNT_W'(EN_HOLD - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_q;   // 1 = m1 was granted last
    logic             sel_q;    // granted requester: 0 = flash, 1 = ethernet
    logic             we_q;     // latched write flag of the granted access

    // m0 wins when it is the only requester, or when both request and m1
    // was granted last. m1 wins in the mirror-image cases.
    logic grant0, grant1;
    assign grant0 = m0_req && (!m1_req || last_q);
    assign grant1 = m1_req && (!m0_req || !last_q);

    // NOTE: every state and output register below is assigned with <= so
    // that all of them update together from values sampled before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            m0_rdat    <= '0;
            m0_ack     <= 1'b0;
            m1_rdat    <= '0;
            m1_ack     <= 1'b0;
            ef_a       <= '0;
            ef_d_o     <= '0;
            ef_d_oe    <= 1'b0;
            flash_ce_n <= 1'b1;
            flash_oe_n <= 1'b1;
            flash_we_n <= 1'b1;
            enet_rd_n  <= 1'b1;
            enet_wr_n  <= 1'b1;
            enet_be_n  <= 4'hF;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant0) begin
                        state_q    <= SETUP;
                        cnt_q      <= FL_SETUP_C;
                        last_q     <= 1'b0;
                        sel_q      <= 1'b0;
                        we_q       <= m0_we;
                        ef_a       <= m0_adr;
                        ef_d_o     <= m0_wdat;
                        ef_d_oe    <= m0_we;
                        flash_ce_n <= 1'b0;
                    end else if (grant1) begin
                        state_q    <= SETUP;
                        cnt_q      <= EN_SETUP_C;
                        last_q     <= 1'b1;
                        sel_q      <= 1'b1;
                        we_q       <= m1_we;
                        ef_a       <= m1_adr;
                        ef_d_o     <= m1_wdat;
                        ef_d_oe    <= m1_we;
                        enet_be_n  <= m1_be_n;
                    end
                end

                SETUP: begin
                    if (cnt_q == '0) begin
                        state_q <= STROBE;
                        if (!sel_q) begin
                            cnt_q      <= FL_STROBE_C;
                            flash_oe_n <= we_q;
                            flash_we_n <= !we_q;
                        end else begin
                            cnt_q      <= EN_STROBE_C;
                            enet_rd_n  <= we_q;
                            enet_wr_n  <= !we_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                STROBE: begin
                    if (cnt_q == '0) begin
                        // The read data is captured on the edge that ends the strobe.
                        state_q    <= HOLD;
                        cnt_q      <= sel_q ? EN_HOLD_C : FL_HOLD_C;
                        flash_oe_n <= 1'b1;
                        flash_we_n <= 1'b1;
                        enet_rd_n  <= 1'b1;
                        enet_wr_n  <= 1'b1;
                        if (!we_q) begin
                            if (sel_q) m1_rdat <= ef_d_i;
                            else       m0_rdat <= ef_d_i;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                HOLD: begin
                    if (cnt_q == '0) begin
                        // Release the selects and the data driver for bus turnaround.
                        state_q    <= TURN;
                        flash_ce_n <= 1'b1;
                        enet_be_n  <= 4'hF;
                        ef_d_oe    <= 1'b0;
                        m0_ack     <= !sel_q;
                        m1_ack     <= sel_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                TURN: begin
                    state_q <= IDLE;
                    m0_ack  <= 1'b0;
                    m1_ack  <= 1'b0;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ef_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ef_bus_arbiter
//   Directed bench for ef_bus_arbiter with default parameters.
//   Inputs change 1 ns after a rising edge and outputs are sampled at the
//   same point. Cycle i of an observation window is the state that follows
//   the i-th edge counted from the grant edge. With this numbering a flash
//   ack falls in cycle 9 and an ethernet ack in cycle 6.
// ---------------------------------------------------------------------------
module tb_ef_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [22:0] m0_adr, m1_adr;
    logic [31:0] m0_wdat, m1_wdat, m0_rdat, m1_rdat;
    logic        m0_ack, m1_ack;
    logic [3:0]  m1_be_n, enet_be_n;
    logic [22:0] ef_a;
    logic [31:0] ef_d_o, ef_d_i;
    logic        ef_d_oe;
    logic        flash_ce_n, flash_oe_n, flash_we_n, enet_rd_n, enet_wr_n;

    int tests = 0;
    int fails = 0;

    // Statistics gathered by observe().
    int          ce_cnt, oe_cnt, fwe_cnt, rd_cnt, wr_cnt, doe_cnt, be_cnt;
    int          be_match, doe_first, n_ack, overlap;
    int          ack_who  [8];
    int          ack_time [8];
    logic [31:0] ack_rdat [8];
    logic [22:0] a_first;
    logic [31:0] d_first;

    always #5 clk = ~clk;

    ef_bus_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0_req     (m0_req),
        .m0_we      (m0_we),
        .m0_adr     (m0_adr),
        .m0_wdat    (m0_wdat),
        .m0_rdat    (m0_rdat),
        .m0_ack     (m0_ack),
        .m1_req     (m1_req),
        .m1_we      (m1_we),
        .m1_adr     (m1_adr),
        .m1_wdat    (m1_wdat),
        .m1_be_n    (m1_be_n),
        .m1_rdat    (m1_rdat),
        .m1_ack     (m1_ack),
        .ef_a       (ef_a),
        .ef_d_o     (ef_d_o),
        .ef_d_oe    (ef_d_oe),
        .ef_d_i     (ef_d_i),
        .flash_ce_n (flash_ce_n),
        .flash_oe_n (flash_oe_n),
        .flash_we_n (flash_we_n),
        .enet_rd_n  (enet_rd_n),
        .enet_wr_n  (enet_wr_n),
        .enet_be_n  (enet_be_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs ncyc cycles and gathers strobe, output-enable and ack statistics.
    // When drop is set, a requester lowers its request in its ack cycle.
    task automatic observe(input int ncyc, input bit drop);
        ce_cnt = 0; oe_cnt = 0; fwe_cnt = 0; rd_cnt = 0; wr_cnt = 0;
        doe_cnt = 0; be_cnt = 0; be_match = 0; doe_first = 0;
        n_ack = 0; overlap = 0;
        for (int i = 1; i <= ncyc; i++) begin
            step();
            if (i == 1) begin
                a_first = ef_a;
                d_first = ef_d_o;
            end
            if (!flash_ce_n) ce_cnt++;
            if (!flash_oe_n) oe_cnt++;
            if (!flash_we_n) fwe_cnt++;
            if (!enet_rd_n)  rd_cnt++;
            if (!enet_wr_n)  wr_cnt++;
            if (enet_be_n != 4'hF)    be_cnt++;
            if (enet_be_n == 4'b1100) be_match++;
            if (ef_d_oe) begin
                doe_cnt++;
                if (doe_first == 0) doe_first = i;
            end
            if (m0_ack && m1_ack) overlap++;
            if ((m0_ack || m1_ack) && n_ack < 8) begin
                ack_who[n_ack]  = m1_ack ? 1 : 0;
                ack_time[n_ack] = i;
                ack_rdat[n_ack] = m1_ack ? m1_rdat : m0_rdat;
                n_ack++;
            end
            if (drop && m0_ack) m0_req = 1'b0;
            if (drop && m1_ack) m1_req = 1'b0;
        end
    endtask

    initial begin
        // NOTE: stimulus uses blocking assignments 1 ns after the edge, so the
        // DUT never samples an input on the same edge it is changed.
        rst_n = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_wdat = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_wdat = '0; m1_be_n = 4'hF;
        ef_d_i = '0;
        repeat (3) step();

        // Reset values.
        check("rst_strobes", {27'd0, flash_ce_n, flash_oe_n, flash_we_n, enet_rd_n, enet_wr_n}, 32'h1F);
        check("rst_be_n", {28'd0, enet_be_n}, 32'hF);
        check("rst_oe_ack", {29'd0, ef_d_oe, m0_ack, m1_ack}, 32'h0);
        check("rst_ef_a", {9'd0, ef_a}, 32'h0);
        check("rst_ef_d_o", ef_d_o, 32'h0);
        check("rst_rdat", m0_rdat | m1_rdat, 32'h0);
        rst_n = 1'b1;
        step();
        check("idle_ce_n", {31'd0, flash_ce_n}, 32'h1);

        // Flash read with default wait states.
        m0_req = 1'b1; m0_we = 1'b0; m0_adr = 23'h012345; ef_d_i = 32'hCAFE0001;
        observe(12, 1'b1);
        check("fr_ce_cycles", ce_cnt, 8);
        check("fr_oe_cycles", oe_cnt, 6);
        check("fr_we_cycles", fwe_cnt, 0);
        check("fr_doe_cycles", doe_cnt, 0);
        check("fr_enet_quiet", rd_cnt + wr_cnt + be_cnt, 0);
        check("fr_addr", {9'd0, a_first}, 32'h012345);
        check("fr_n_ack", n_ack, 1);
        check("fr_ack_who", ack_who[0], 0);
        check("fr_ack_time", ack_time[0], 9);
        check("fr_rdat", ack_rdat[0], 32'hCAFE0001);
        check("fr_rdat_hold", m0_rdat, 32'hCAFE0001);
        check("fr_addr_hold", {9'd0, ef_a}, 32'h012345);

        // Ethernet write.
        ef_d_i = 32'h12340000;
        m1_req = 1'b1; m1_we = 1'b1; m1_adr = 23'h000300; m1_be_n = 4'b1100;
        m1_wdat = 32'h0000BEEF;
        observe(10, 1'b1);
        check("ew_doe_cycles", doe_cnt, 5);
        check("ew_wr_cycles", wr_cnt, 3);
        check("ew_rd_cycles", rd_cnt, 0);
        check("ew_be_cycles", be_match, 5);
        check("ew_be_any", be_cnt, 5);
        check("ew_flash_quiet", ce_cnt + oe_cnt + fwe_cnt, 0);
        check("ew_data", d_first, 32'h0000BEEF);
        check("ew_addr", {9'd0, a_first}, 32'h000300);
        check("ew_n_ack", n_ack, 1);
        check("ew_ack_who", ack_who[0], 1);
        check("ew_ack_time", ack_time[0], 6);
        check("ew_m0_rdat_kept", m0_rdat, 32'hCAFE0001);
        check("ew_m1_rdat_kept", m1_rdat, 32'h0);

        // Both requesters held continuously from reset: m0, m1, m0, m1.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        ef_d_i = 32'h5A5A0002;
        m0_req = 1'b1; m0_we = 1'b0; m0_adr = 23'h000010;
        m1_req = 1'b1; m1_we = 1'b0; m1_adr = 23'h000020; m1_be_n = 4'b0000;
        observe(34, 1'b0);
        check("rr_n_ack", n_ack, 4);
        check("rr_overlap", overlap, 0);
        check("rr_order", {ack_who[0][7:0], ack_who[1][7:0], ack_who[2][7:0], ack_who[3][7:0]}, 32'h00010001);
        check("rr_t0", ack_time[0], 9);
        check("rr_t1", ack_time[1], 16);
        check("rr_t2", ack_time[2], 26);
        check("rr_t3", ack_time[3], 33);
        check("rr_m1_rdat", ack_rdat[1], 32'h5A5A0002);

        // Flash read immediately followed by ethernet write: turnaround.
        m0_req = 1'b0; m1_req = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_adr = 23'h000040;
        m1_req = 1'b1; m1_we = 1'b1; m1_be_n = 4'b1100; m1_wdat = 32'h00C0FFEE;
        observe(18, 1'b1);
        check("ta_doe_first", doe_first, 11);
        check("ta_doe_cycles", doe_cnt, 5);
        check("ta_acks", {ack_who[0][7:0], ack_who[1][7:0]}, 32'h0001);
        check("ta_ack_times", {ack_time[0][15:0], ack_time[1][15:0]}, {16'd9, 16'd16});

        // Reset in the middle of a flash write strobe.
        m0_req = 1'b0; m1_req = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m0_req = 1'b1; m0_we = 1'b1; m0_adr = 23'h000055; m0_wdat = 32'h55AA55AA;
        repeat (3) step();
        check("mr_we_low", {30'd0, flash_we_n, flash_ce_n}, 32'h0);
        check("mr_doe_high", {31'd0, ef_d_oe}, 32'h1);
        rst_n = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0;
        step();
        check("mr_strobes", {29'd0, flash_we_n, flash_ce_n, ef_d_oe}, 32'h6);
        check("mr_no_ack0", {30'd0, m0_ack, m1_ack}, 32'h0);
        step();
        check("mr_no_ack1", {30'd0, m0_ack, m1_ack}, 32'h0);
        rst_n = 1'b1;
        observe(12, 1'b1);
        check("mr_n_ack", n_ack, 1);
        check("mr_first_who", ack_who[0], 0);
        check("mr_first_time", ack_time[0], 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
